// File: rtl/conv_pool_param.sv
// conv_pool_param: 3x3 zero-padded convolution over a square image for up to
// three kernel channels in parallel, written to per-channel layer-0 memories.
// Optional 2x2 unsigned max pooling into layer-1 memories is built only when
// the macro CONV_MAXPOOL_EN is defined; without it the job ends after the last
// convolution write.
module conv_pool_param #(
    parameter int IMG_W = 64,
    parameter int DW    = 20,
    parameter int FRAC  = 16,
    parameter int NCH   = 2,
    localparam int AW   = 2 * $clog2(IMG_W)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ready,
    output logic          busy,
    input  logic          wt_we,
    input  logic [4:0]    wt_sel,
    input  logic [DW-1:0] wt_data,
    output logic [AW-1:0] iaddr,
    input  logic [DW-1:0] idata,
    output logic          cwr,
    output logic [AW-1:0] caddr_wr,
    output logic [DW-1:0] cdata_wr,
    output logic          crd,
    output logic [AW-1:0] caddr_rd,
    input  logic [DW-1:0] cdata_rd,
    output logic [2:0]    csel
);

    localparam int LW = AW / 2;
    localparam logic [AW-1:0] PIX_LAST = '1;
    localparam logic signed [2*DW-1:0] ROUND = (2*DW)'(1) <<< (FRAC - 1);

    typedef enum logic [2:0] {IDLE, CONV_RD, CONV_WR, POOL_RD, POOL_WR} state_t;

    state_t state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] pix_q, pix_d;
    logic          busy_q, busy_d;
    logic          in_q, in_d;
    logic signed [2*DW-1:0] acc_q [NCH];
    logic signed [2*DW-1:0] acc_d [NCH];
    logic signed [DW-1:0]   w_q [NCH][10];
    logic signed [DW-1:0]   w_d [NCH][10];

    logic [LW-1:0] pix_row, pix_col;
    int            tap_r, tap_c;
    logic          tap_in;
    logic [AW-1:0] tap_addr;
    logic [3:0]    tap_k;
    logic signed [DW-1:0]   tap_data;
    logic signed [2*DW-1:0] conv_sum [NCH];
    logic [DW-1:0]          conv_out [NCH];
    logic                   unused_sum;

`ifdef CONV_MAXPOOL_EN
    localparam logic [AW-1:0] POOL_LAST = AW'((IMG_W / 2) * (IMG_W / 2) - 1);
    logic [1:0]    pch_q, pch_d;
    logic [DW-1:0] max_q, max_d;
    logic [AW-1:0] pool_rd_addr;
    // 2x2 block address: pooled row/col doubled, low bits walk the block
    assign pool_rd_addr = {pix_q[AW-3:LW-1], cnt_q[1], pix_q[LW-2:0], cnt_q[0]};
`else
    logic unused_rd;
    assign unused_rd = ^cdata_rd;
`endif

    assign pix_row  = pix_q[AW-1:LW];
    assign pix_col  = pix_q[LW-1:0];
    assign tap_k    = cnt_q - 4'd1;
    assign tap_data = in_q ? $signed(idata) : '0;
    assign busy     = busy_q;

    // Neighbour tap k = cnt (row-major around the current pixel) and whether it lies inside the image
    always_comb begin
        tap_r    = int'(pix_row) + int'(cnt_q) / 3 - 1;
        tap_c    = int'(pix_col) + int'(cnt_q) % 3 - 1;
        tap_in   = (cnt_q < 4'd9) && (tap_r >= 0) && (tap_r < IMG_W) &&
                   (tap_c >= 0) && (tap_c < IMG_W);
        tap_addr = {tap_r[LW-1:0], tap_c[LW-1:0]};
    end

    // Per-channel bias, rounding and ReLU, then pick the fixed-point window
    always_comb begin
        unused_sum = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            conv_sum[c] = acc_q[c] + ((2*DW)'(w_q[c][9]) <<< FRAC) + ROUND;
            conv_out[c] = conv_sum[c][2*DW-1] ? '0 : conv_sum[c][FRAC+DW-1:FRAC];
            unused_sum  = unused_sum ^ (^conv_sum[c]);
        end
    end

    // Next-state, counters, accumulators and weight file
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pix_d   = pix_q;
        in_d    = 1'b0;
        acc_d   = acc_q;
        w_d     = w_q;
`ifdef CONV_MAXPOOL_EN
        pch_d   = pch_q;
        max_d   = max_q;
`endif
        case (state_q)
            IDLE: begin
                if (wt_we) begin
                    for (int c = 0; c < NCH; c++) begin
                        for (int k = 0; k < 10; k++) begin
                            if (wt_sel == 5'(c * 10 + k)) begin
                                w_d[c][k] = wt_data;
                            end
                        end
                    end
                end
                if (ready) begin
                    state_d = CONV_RD;
                    cnt_d   = '0;
                    pix_d   = '0;
                end
            end
            CONV_RD: begin
                in_d = tap_in;
                for (int c = 0; c < NCH; c++) begin
                    if (cnt_q == 4'd0) begin
                        acc_d[c] = '0;
                    end else if (cnt_q <= 4'd9) begin
                        acc_d[c] = acc_q[c] + (2*DW)'(tap_data) * (2*DW)'(w_q[c][tap_k]);
                    end
                end
                if (cnt_q == 4'd10) begin
                    state_d = CONV_WR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            CONV_WR: begin
                if (cnt_q == 4'(NCH - 1)) begin
                    cnt_d = '0;
                    if (pix_q == PIX_LAST) begin
                        pix_d = '0;
`ifdef CONV_MAXPOOL_EN
                        state_d = POOL_RD;
                        pch_d   = '0;
`else
                        state_d = IDLE;
`endif
                    end else begin
                        pix_d   = pix_q + 1'b1;
                        state_d = CONV_RD;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
`ifdef CONV_MAXPOOL_EN
            POOL_RD: begin
                if (cnt_q == 4'd1) begin
                    max_d = cdata_rd;
                end else if ((cnt_q >= 4'd2) && (cdata_rd > max_q)) begin
                    max_d = cdata_rd;
                end
                if (cnt_q == 4'd4) begin
                    state_d = POOL_WR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            POOL_WR: begin
                state_d = POOL_RD;
                if (pix_q == POOL_LAST) begin
                    pix_d = '0;
                    if (pch_q == 2'(NCH - 1)) begin
                        state_d = IDLE;
                    end else begin
                        pch_d = pch_q + 2'd1;
                    end
                end else begin
                    pix_d = pix_q + 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Memory-port outputs decoded from the current state and counters
    always_comb begin
        cwr      = 1'b0;
        crd      = 1'b0;
        csel     = '0;
        iaddr    = '0;
        caddr_wr = '0;
        caddr_rd = '0;
        cdata_wr = '0;
        case (state_q)
            CONV_RD: begin
                if (tap_in) iaddr = tap_addr;
            end
            CONV_WR: begin
                cwr      = 1'b1;
                csel     = 3'(2 * int'(cnt_q) + 1);
                caddr_wr = pix_q;
                for (int c = 0; c < NCH; c++) begin
                    if (cnt_q == 4'(c)) cdata_wr = conv_out[c];
                end
            end
`ifdef CONV_MAXPOOL_EN
            POOL_RD: begin
                csel = 3'(2 * int'(pch_q) + 1);
                if (cnt_q < 4'd4) begin
                    crd      = 1'b1;
                    caddr_rd = pool_rd_addr;
                end
            end
            POOL_WR: begin
                cwr      = 1'b1;
                csel     = 3'(2 * int'(pch_q) + 2);
                caddr_wr = pix_q;
                cdata_wr = max_q;
            end
`endif
            default: ;
        endcase
    end

    // State and datapath registers; reset clears everything including weights
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pix_q   <= '0;
            busy_q  <= 1'b0;
            in_q    <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                acc_q[c] <= '0;
                for (int k = 0; k < 10; k++) w_q[c][k] <= '0;
            end
`ifdef CONV_MAXPOOL_EN
            pch_q   <= '0;
            max_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pix_q   <= pix_d;
            busy_q  <= busy_d;
            in_q    <= in_d;
            acc_q   <= acc_d;
            w_q     <= w_d;
`ifdef CONV_MAXPOOL_EN
            pch_q   <= pch_d;
            max_q   <= max_d;
`endif
        end
    end

endmodule

// File: tb/tb_conv_pool_param.sv
// tb_conv_pool_param: directed bench for conv_pool_param on a 4x4 image with
// two channels. Expected writes come from a small arithmetic model and are
// queued before each job, then matched against every cwr the DUT issues.
module tb_conv_pool_param;

    localparam int IMG_W = 4;
    localparam int DW    = 20;
    localparam int FRAC  = 16;
    localparam int NCH   = 2;
    localparam int AW    = 4;
    localparam int NPIX  = IMG_W * IMG_W;
`ifdef CONV_MAXPOOL_EN
    localparam int EXP_CYC = NPIX * (11 + NCH) + NCH * (IMG_W / 2) * (IMG_W / 2) * 6;
`else
    localparam int EXP_CYC = NPIX * (11 + NCH);
`endif

    typedef struct {
        logic [2:0]    sel;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          ready;
    logic          busy;
    logic          wt_we;
    logic [4:0]    wt_sel;
    logic [DW-1:0] wt_data;
    logic [AW-1:0] iaddr;
    logic [DW-1:0] idata;
    logic          cwr;
    logic [AW-1:0] caddr_wr;
    logic [DW-1:0] cdata_wr;
    logic          crd;
    logic [AW-1:0] caddr_rd;
    logic [DW-1:0] cdata_rd;
    logic [2:0]    csel;

    logic signed [DW-1:0] img [NPIX];
    logic signed [DW-1:0] w_model [NCH][10];
    logic [DW-1:0] l0_model [NCH][NPIX];
    logic [DW-1:0] l0mem [NCH][NPIX];
    logic [DW-1:0] l1mem [NCH][NPIX/4];
    exp_t sb_q [$];

    int vectors = 0;
    int miscompares = 0;

    conv_pool_param #(.IMG_W(IMG_W), .DW(DW), .FRAC(FRAC), .NCH(NCH)) dut (
        .clk(clk), .reset(reset), .ready(ready), .busy(busy),
        .wt_we(wt_we), .wt_sel(wt_sel), .wt_data(wt_data),
        .iaddr(iaddr), .idata(idata),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
        .csel(csel)
    );

    always #5 clk = ~clk;

    function automatic int readChannel(input logic [2:0] sel);
        if (sel >= 3'd1 && sel <= 3'(2 * NCH - 1) && sel[0]) return (int'(sel) - 1) / 2;
        return 0;
    endfunction

    // Synchronous image and layer-0 memories with one cycle of read latency
    always @(posedge clk) begin
        idata    <= img[iaddr];
        cdata_rd <= l0mem[readChannel(csel)][caddr_rd];
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Every result write is matched against the head of the scoreboard and stored
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (cwr === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_cwr", 64'(caddr_wr), 64'hFFFF);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("csel", 64'(csel), 64'(e.sel));
                    checkOutput("caddr_wr", 64'(caddr_wr), 64'(e.addr));
                    checkOutput("cdata_wr", 64'(cdata_wr), 64'(e.data));
                end
                if (csel[0]) l0mem[readChannel(csel)][caddr_wr] = cdata_wr;
                else if (csel != 3'd0) l1mem[(int'(csel) - 2) / 2][caddr_wr[1:0]] = cdata_wr;
            end
`ifndef CONV_MAXPOOL_EN
            checkOutput("crd_off", 64'(crd), 64'd0);
`endif
        end
    end

    function automatic logic [DW-1:0] convModel(input int c, input int pix);
        longint acc = 0;
        int r = pix / IMG_W;
        int col = pix % IMG_W;
        for (int k = 0; k < 9; k++) begin
            int rr = r + k / 3 - 1;
            int cc = col + k % 3 - 1;
            if (rr >= 0 && rr < IMG_W && cc >= 0 && cc < IMG_W)
                acc += longint'(img[rr * IMG_W + cc]) * longint'(w_model[c][k]);
        end
        acc += longint'(w_model[c][9]) <<< FRAC;
        acc += 64'sd1 <<< (FRAC - 1);
        if (acc < 0) return '0;
        return acc[FRAC+DW-1:FRAC];
    endfunction

    task automatic pushExpected();
        exp_t e;
        for (int p = 0; p < NPIX; p++) begin
            for (int c = 0; c < NCH; c++) begin
                l0_model[c][p] = convModel(c, p);
                e.sel  = 3'(2 * c + 1);
                e.addr = AW'(p);
                e.data = l0_model[c][p];
                sb_q.push_back(e);
            end
        end
`ifdef CONV_MAXPOOL_EN
        for (int c = 0; c < NCH; c++) begin
            for (int p = 0; p < NPIX / 4; p++) begin
                logic [DW-1:0] m = '0;
                int pr = p / (IMG_W / 2);
                int pc = p % (IMG_W / 2);
                for (int b = 0; b < 4; b++) begin
                    int idx = (2 * pr + b / 2) * IMG_W + 2 * pc + b % 2;
                    if (l0_model[c][idx] > m) m = l0_model[c][idx];
                end
                e.sel  = 3'(2 * c + 2);
                e.addr = AW'(p);
                e.data = m;
                sb_q.push_back(e);
            end
        end
`endif
    endtask

    task automatic applyStimulus(input logic rdy, input logic we, input logic [4:0] sel, input logic [DW-1:0] dat);
        @(posedge clk);
        #1;
        ready   = rdy;
        wt_we   = we;
        wt_sel  = sel;
        wt_data = dat;
    endtask

    task automatic writeWeight(input int sel, input logic [DW-1:0] dat);
        applyStimulus(1'b0, 1'b1, 5'(sel), dat);
        applyStimulus(1'b0, 1'b0, 5'd0, '0);
        if (sel < NCH * 10) w_model[sel / 10][sel % 10] = dat;
    endtask

    task automatic setChannel(input int c, input logic [DW-1:0] tap, input logic [DW-1:0] bias);
        for (int k = 0; k < 9; k++) writeWeight(c * 10 + k, tap);
        writeWeight(c * 10 + 9, bias);
    endtask

    // Start a job, optionally poke ready/wt_we mid-job, and time it to completion
    task automatic runJob(input string tag, input int pulse_at);
        int cycles = 0;
        pushExpected();
        applyStimulus(1'b1, 1'b0, 5'd0, '0);
        checkOutput({tag, "_busy_before"}, 64'(busy), 64'd0);
        applyStimulus(1'b0, 1'b0, 5'd0, '0);
        checkOutput({tag, "_busy_rise"}, 64'(busy), 64'd1);
        while (busy === 1'b1 && cycles < 2000) begin
            if (cycles == pulse_at) applyStimulus(1'b1, 1'b1, 5'd4, 20'h12345);
            else applyStimulus(1'b0, 1'b0, 5'd0, '0);
            cycles++;
        end
        checkOutput({tag, "_cycles"}, 64'(cycles), 64'(EXP_CYC));
        checkOutput({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        reset   = 1'b1;
        ready   = 1'b0;
        wt_we   = 1'b0;
        wt_sel  = '0;
        wt_data = '0;
        for (int c = 0; c < NCH; c++) for (int k = 0; k < 10; k++) w_model[c][k] = '0;
        for (int p = 0; p < NPIX; p++) img[p] = 20'sh10000;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_cwr", 64'(cwr), 64'd0);
        checkOutput("rst_crd", 64'(crd), 64'd0);
        checkOutput("rst_csel", 64'(csel), 64'd0);
        checkOutput("rst_iaddr", 64'(iaddr), 64'd0);
        checkOutput("rst_caddr_wr", 64'(caddr_wr), 64'd0);
        checkOutput("rst_caddr_rd", 64'(caddr_rd), 64'd0);
        checkOutput("rst_cdata_wr", 64'(cdata_wr), 64'd0);
        reset = 1'b0;

        $display("[TB] job A: unit taps, -1.0 taps on ch1, busy-time pokes");
        setChannel(0, 20'h10000, 20'h0);
        setChannel(1, 20'hF0000, 20'h0);
        runJob("jobA", 20);
        checkOutput("corner_addr0", 64'(l0mem[0][0]), 64'h40000);
        checkOutput("inner_addr5", 64'(l0mem[0][5]), 64'h90000);
        checkOutput("edge_addr1", 64'(l0mem[0][1]), 64'h60000);
        checkOutput("ch1_relu_addr5", 64'(l0mem[1][5]), 64'd0);

        $display("[TB] job A repeat: out-of-range select ignored, weights unchanged");
        writeWeight(20, 20'h50000);
        writeWeight(31, 20'h50000);
        runJob("jobA2", -1);

        $display("[TB] job B: rounding on half centre tap, bias on ch1");
        for (int p = 0; p < NPIX; p++) img[p] = 20'sh00001;
        setChannel(0, 20'h0, 20'h0);
        writeWeight(4, 20'h08000);
        setChannel(1, 20'h0, 20'h10000);
        runJob("jobB", -1);
        checkOutput("round_addr0", 64'(l0mem[0][0]), 64'h1);

        $display("[TB] job C: random taps and image");
        for (int p = 0; p < NPIX; p++) img[p] = DW'($urandom_range(0, 20'h1FFFF));
        for (int s = 0; s < NCH * 10; s++) begin
            int v = int'($urandom_range(0, 262143)) - 131072;
            writeWeight(s, v[DW-1:0]);
        end
        runJob("jobC", -1);

        $display("[TB] job D: pooling block pattern");
        for (int p = 0; p < NPIX; p++) img[p] = DW'($urandom_range(0, 15));
        img[0] = 20'sd3;
        img[1] = 20'sd7;
        img[4] = 20'sd5;
        img[5] = 20'sd2;
        setChannel(0, 20'h0, 20'h0);
        writeWeight(4, 20'h10000);
        runJob("jobD", -1);
        checkOutput("l0_addr1", 64'(l0mem[0][1]), 64'd7);
`ifdef CONV_MAXPOOL_EN
        checkOutput("pool_addr0", 64'(l1mem[0][0]), 64'd7);
`endif

        $display("[TB] job E: reset during pixel 10, then restart");
        for (int p = 0; p < NPIX; p++) img[p] = 20'sh10000;
        pushExpected();
        applyStimulus(1'b1, 1'b0, 5'd0, '0);
        applyStimulus(1'b0, 1'b0, 5'd0, '0);
        repeat (10 * (11 + NCH) + 2) applyStimulus(1'b0, 1'b0, 5'd0, '0);
        #2;
        reset = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1;
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_cwr", 64'(cwr), 64'd0);
        checkOutput("midrst_iaddr", 64'(iaddr), 64'd0);
        reset = 1'b0;
        for (int c = 0; c < NCH; c++) for (int k = 0; k < 10; k++) w_model[c][k] = '0;
        runJob("jobE", -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
